// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file.
// Preset codes are the display "dash" and "blank" glyph codes.
package regfile_pkg;

    localparam int PRESET_DASH  = 127;
    localparam int PRESET_BLANK = 126;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks a pointer over every register under valid/ready
// and pulses dump_done the cycle after the final beat is accepted.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W-1:0] dump_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    // State, pointer and done registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= {ADDR_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a start request while streaming is simply dropped
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = STREAM;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (ptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Outputs decoded straight from the registers
    always_comb begin
        dump_addr = ptr_q;
        dump_done = done_q;
        case (state_q)
            STREAM: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
            end
            default: begin
                dump_valid = 1'b0;
                dump_busy  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: N combinational read ports with optional write
// bypass, optional hardwired zero register, top-two presets and a dump port.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int N_READ    = 3,
    parameter int ZERO_REG  = 1,
    parameter int PRESET_HI = 1,
    parameter int BYPASS    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [N_READ*ADDR_W-1:0]   raddr,
    output logic [N_READ*DATA_W-1:0]   rdata,
    input  logic                       dump_start,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [ADDR_W-1:0]          dump_addr,
    output logic [DATA_W-1:0]          dump_data,
    output logic                       dump_busy,
    output logic                       dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              we_eff;
    // The dump pointer is an extra internal read port at index N_READ
    logic [ADDR_W-1:0] rd_addr [N_READ+1];
    logic [DATA_W-1:0] rd_val  [N_READ+1];

    regfile_dump_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .clock      (clock),
        .reset      (reset),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .dump_addr  (dump_addr)
    );

    assign we_eff = we && !((ZERO_REG != 0) && (waddr == {ADDR_W{1'b0}}));

    // Next contents of the storage array
    always_comb begin
        regs_d = regs_q;
        if (we_eff) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[waddr] = regs_q[waddr];
        end
    end

    // Storage array with reset-time presets in the top two entries
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((PRESET_HI != 0) && (j == DEPTH - 1)) begin
                    regs_q[j] <= DATA_W'(PRESET_DASH);
                end else if ((PRESET_HI != 0) && (j == DEPTH - 2)) begin
                    regs_q[j] <= DATA_W'(PRESET_BLANK);
                end else begin
                    regs_q[j] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Gather read addresses
    always_comb begin
        for (int i = 0; i < N_READ; i++) begin
            rd_addr[i] = raddr[i*ADDR_W +: ADDR_W];
        end
        rd_addr[N_READ] = dump_addr;
    end

    // Read muxes: zero register first, then bypass, then storage
    always_comb begin
        for (int i = 0; i <= N_READ; i++) begin
            if ((ZERO_REG != 0) && (rd_addr[i] == {ADDR_W{1'b0}})) begin
                rd_val[i] = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && we_eff && (waddr == rd_addr[i])) begin
                rd_val[i] = wdata;
            end else begin
                rd_val[i] = regs_q[rd_addr[i]];
            end
        end
    end

    // Pack the read results onto the output ports
    always_comb begin
        rdata = {N_READ*DATA_W{1'b0}};
        for (int i = 0; i < N_READ; i++) begin
            rdata[i*DATA_W +: DATA_W] = rd_val[i];
        end
        dump_data = rd_val[N_READ];
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: default 32x32 instance with bypass,
// plus a small 8x16, four-port instance without bypass.
module tb_regfile_param;

    localparam int AW = 5, DW = 32, NR = 3, DEPTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic we = 1'b0, dump_start = 1'b0, dump_ready = 1'b1;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] rdata;
    logic dump_valid, dump_busy, dump_done;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;

    logic s_we = 1'b0, s_dump_start = 1'b0, s_dump_ready = 1'b1;
    logic [2:0] s_waddr = '0;
    logic [15:0] s_wdata = '0;
    logic [11:0] s_raddr = '0;
    logic [63:0] s_rdata;
    logic s_dump_valid, s_dump_busy, s_dump_done;
    logic [2:0] s_dump_addr;
    logic [15:0] s_dump_data;

    regfile_param u_dut (
        .clock(clock), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .dump_start(dump_start), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .N_READ(4), .BYPASS(0)) u_small (
        .clock(clock), .reset(reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr(s_raddr), .rdata(s_rdata), .dump_start(s_dump_start), .dump_valid(s_dump_valid),
        .dump_ready(s_dump_ready), .dump_addr(s_dump_addr), .dump_data(s_dump_data),
        .dump_busy(s_dump_busy), .dump_done(s_dump_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model (register file as a plain array) ----
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic [DW-1:0] mem [DEPTH];
    beat_t beat_q[$];
    logic [NR*DW-1:0] rd_q[$];
    bit m_busy = 1'b0;
    int m_left = 0;
    bit done_exp = 1'b0;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[DEPTH-1] = 32'd127;
        mem[DEPTH-2] = 32'd126;
        beat_q.delete();
        m_busy = 1'b0;
        m_left = 0;
        done_exp = 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_read(int a);
        if (a == 0) return '0;
        if (we && waddr != 0 && int'(waddr) == a) return wdata;
        return mem[a];
    endfunction

    always @(posedge clock) begin
        bit start_ok;
        if (reset) begin
            model_reset();
        end else begin
            start_ok = dump_start && !m_busy;
            if (we && waddr != 0) mem[waddr] = wdata;
            done_exp = 1'b0;
            if (m_busy && dump_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    done_exp = 1'b1;
                end
            end
            if (start_ok) begin
                for (int i = 0; i < DEPTH; i++)
                    beat_q.push_back('{a: AW'(i), d: (i == 0) ? '0 : mem[i]});
                m_busy = 1'b1;
                m_left = DEPTH;
            end
        end
    end

    // ---------------- monitor ----------------
    bit prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;

    always @(negedge clock) begin
        beat_t b;
        logic [NR*DW-1:0] r;
        if (!reset) begin
            chk("dump_valid", 64'(dump_valid), 64'(m_busy));
            chk("dump_busy", 64'(dump_busy), 64'(m_busy));
            chk("dump_done", 64'(dump_done), 64'(done_exp));
            if (prev_stall && dump_valid) chk("addr_hold", 64'(dump_addr), 64'(prev_addr));
            if (dump_valid && dump_ready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 64'(dump_addr), 64'hFFFF);
                end else begin
                    b = beat_q.pop_front();
                    chk("dump_addr", 64'(dump_addr), 64'(b.a));
                    chk("dump_data", 64'(dump_data), 64'(b.d));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_addr = dump_addr;
            if (rd_q.size() > 0) begin
                r = rd_q.pop_front();
                for (int i = 0; i < NR; i++)
                    chk($sformatf("rdata%0d", i), 64'(rdata[i*DW +: DW]), 64'(r[i*DW +: DW]));
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Small-instance dump monitor against its own model array
    logic [15:0] s_mem [8];
    int s_beat = 0;
    int s_done_cnt = 0;
    always @(negedge clock) begin
        if (!reset) begin
            if (s_dump_valid && s_dump_ready) begin
                chk("s_dump_addr", 64'(s_dump_addr), 64'(s_beat));
                chk("s_dump_data", 64'(s_dump_data), 64'(s_mem[s_beat % 8]));
                s_beat++;
            end
            if (s_dump_done) s_done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(bit w, int wa, logic [DW-1:0] wd, int r0, int r1, int r2);
        @(posedge clock); #1;
        we = w; waddr = AW'(wa); wdata = wd; dump_start = 1'b0;
        raddr = {AW'(r2), AW'(r1), AW'(r0)};
        rd_q.push_back({exp_read(r2), exp_read(r1), exp_read(r0)});
    endtask

    task automatic start_dump();
        @(posedge clock); #1;
        we = 1'b0; dump_start = 1'b1; dump_ready = 1'b1;
        @(posedge clock); #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_idle(bit stall, int pulse_at);
        int n = 0;
        while (m_busy && n < 2000) begin
            @(posedge clock); #1;
            dump_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            dump_start = (n == pulse_at);
            n++;
        end
        dump_start = 1'b0;
        if (m_busy) chk("dump_timeout", 64'(m_busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wa;
        for (int i = 0; i < 8; i++) s_mem[i] = '0;
        s_mem[7] = 16'd127;
        s_mem[6] = 16'd126;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // reset state and presets
        cyc(0, 0, 0, 31, 30, 0);
        cyc(0, 0, 0, 5, 1, 29);
        // write with same-cycle bypass, then registered read
        cyc(1, 5, 32'hDEADBEEF, 5, 4, 31);
        cyc(0, 0, 0, 0, 5, 30);
        // zero register ignores writes
        cyc(1, 0, 32'h1234, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // random traffic with biased read-after-write collisions
        for (int i = 0; i < 80; i++) begin
            wa = $urandom_range(0, DEPTH - 1);
            cyc(1'($urandom_range(0, 1)), wa, $urandom(),
                ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, DEPTH - 1),
                $urandom_range(0, DEPTH - 1), ($urandom_range(0, 3) == 0) ? wa : 0);
        end
        cyc(1, 31, 32'hCAFE0031, 31, 30, 1);
        cyc(0, 0, 0, 31, 0, 0);

        // full dump, ready held high, then back-to-back start in the done cycle
        start_dump();
        wait_idle(1'b0, -1);
        dump_start = 1'b1;
        @(posedge clock); #1;
        dump_start = 1'b0;
        // random stalls and a mid-stream start pulse
        wait_idle(1'b1, 5);
        cyc(0, 0, 0, 0, 0, 0);

        // small instance: presets, no-bypass read, independent ports, dump
        @(posedge clock); #1;
        s_raddr = {3'd7, 3'd6, 3'd3, 3'd0};
        #1 chk("s_presets", s_rdata, {16'd127, 16'd126, 16'd0, 16'd0});
        @(posedge clock); #1;
        s_we = 1'b1; s_waddr = 3'd3; s_wdata = 16'hABCD; s_raddr = {3'd7, 3'd6, 3'd0, 3'd3};
        #1 chk("s_nobypass", 64'(s_rdata[15:0]), 64'd0);
        @(posedge clock); #1;
        s_we = 1'b0; s_mem[3] = 16'hABCD;
        s_raddr = {3'd3, 3'd0, 3'd7, 3'd6};
        #1 chk("s_ports", s_rdata, {16'hABCD, 16'd0, 16'd127, 16'd126});
        chk("s_valid_idle", 64'(s_dump_valid), 64'd0);
        @(posedge clock); #1 s_dump_start = 1'b1;
        @(posedge clock); #1 s_dump_start = 1'b0;
        repeat (12) @(posedge clock);
        #1 chk("s_beats", 64'(s_beat), 64'd8);
        chk("s_done_pulses", 64'(s_done_cnt), 64'd1);

        // reset at beat 10
        start_dump();
        for (int i = 0; i < 100 && dump_addr != 5'd10; i++) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b1;
        model_reset();
        #1 chk("valid_in_reset", 64'(dump_valid), 64'd0);
        chk("done_in_reset", 64'(dump_done), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        cyc(0, 0, 0, 31, 30, 5);
        for (int i = 0; i < 20; i++)
            cyc(1, $urandom_range(0, DEPTH - 1), $urandom(), $urandom_range(0, DEPTH - 1), 0, 31);
        cyc(0, 0, 0, 0, 0, 0);
        start_dump();
        wait_idle(1'b1, -1);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        if (beat_q.size() != 0) chk("beats_left", 64'(beat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
